// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing,
// reusable by both the transmit and receive sides.
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 39;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: first-word-fall-through FIFO with an occupancy count.
// A push while full is dropped even if a pop happens on the same edge.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered bytes are framed and shifted out LSB first,
// with back-to-back frames running stop bit straight into the next start bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [7:0]    fifo_dout;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_start),
    .din   (din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        tx_d      = 1'b1;
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          clk_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          // Chain straight into the next frame when another byte is waiting.
          if (!fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_ready     = ~fifo_full;
  assign tx_busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (39 and 4 clocks per bit) checked every cycle
// against a frame-level model, plus hand-computed waveform and timing pins.
module tb_uart_tx;
  localparam int DEPTH = 4;
  localparam int CPB0  = 39;
  localparam int CPB1  = 4;

  logic       clk = 1'b0;
  logic       rst_n    [2];
  logic       tx_start [2];
  logic [7:0] din      [2];
  logic       tx_ready_o [2];
  logic       tx_o       [2];
  logic       done_o     [2];
  logic       busy_o     [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .tx_start(tx_start[0]), .din(din[0]),
    .tx_ready(tx_ready_o[0]), .tx(tx_o[0]), .tx_done_tick(done_o[0]), .tx_busy(busy_o[0]));

  uart_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_start(tx_start[1]), .din(din[1]),
    .tx_ready(tx_ready_o[1]), .tx(tx_o[1]), .tx_done_tick(done_o[1]), .tx_busy(busy_o[1]));

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int cpb(int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  // Model: queue of accepted bytes; an active frame is a 10-bit vector and the
  // line value is the bit at (cycles since frame start) / clocks-per-bit.
  logic [7:0] mq     [2][$];
  logic       mact   [2];
  int         mt     [2];
  logic [9:0] mframe [2];
  logic       exp_tx [2], exp_done [2], exp_busy [2], exp_ready [2];

  always @(posedge clk) begin : model
    logic       acc;
    logic [7:0] b;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        mq[i].delete();
        mact[i]     = 1'b0;
        mt[i]       = 0;
        exp_done[i] = 1'b0;
      end else begin
        acc         = tx_start[i] && (mq[i].size() < DEPTH);
        exp_done[i] = mact[i] && (mt[i] == 10 * cpb(i) - 1);
        if (mact[i]) begin
          if (mt[i] == 10 * cpb(i) - 1) mact[i] = 1'b0;
          else mt[i]++;
        end
        if (!mact[i] && mq[i].size() > 0) begin
          b         = mq[i].pop_front();
          mframe[i] = {1'b1, b, 1'b0};
          mact[i]   = 1'b1;
          mt[i]     = 0;
        end
        if (acc) mq[i].push_back(din[i]);
      end
      exp_tx[i]    = mact[i] ? mframe[i][mt[i] / cpb(i)] : 1'b1;
      exp_busy[i]  = mact[i] || (mq[i].size() > 0);
      exp_ready[i] = (mq[i].size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx[%0d]", i),       tx_o[i],       exp_tx[i]);
        chk($sformatf("done[%0d]", i),     done_o[i],     exp_done[i]);
        chk($sformatf("busy[%0d]", i),     busy_o[i],     exp_busy[i]);
        chk($sformatf("ready[%0d]", i),    tx_ready_o[i], exp_ready[i]);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int i, logic [7:0] b);
    tx_start[i] = 1'b1;
    din[i]      = b;
    @(negedge clk);
    tx_start[i] = 1'b0;
    din[i]      = 8'($urandom);
  endtask

  task automatic wait_done(int i, int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_o[i]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic count_done(int i, int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_o[i]) cnt++;
    end
  endtask

  initial begin
    int         s, d1, d2, cnt;
    logic [9:0] got;
    logic [39:0] w;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; tx_start[i] = 1'b1; din[i] = 8'h55;
    end
    tick(2);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", tx_o[i], 1);
      chk("rst_ready", tx_ready_o[i], 1);
      chk("rst_busy", busy_o[i], 0);
      chk("rst_done", done_o[i], 0);
      tx_start[i] = 1'b0;
      rst_n[i]    = 1'b1;
    end
    tick(3);

    // Single byte 0xA5 from idle, sampled mid-bit.
    wr(0, 8'hA5);
    chk("lat_edgeN_tx", tx_o[0], 1);
    @(negedge clk);
    chk("lat_edgeN1_tx", tx_o[0], 0);
    s = cyc;
    tick(CPB0 / 2);
    for (int k = 0; k < 10; k++) begin
      got[k] = tx_o[0];
      if (k < 9) tick(CPB0);
    end
    chk("a5_bits", got, 10'b1101001010);
    wait_done(0, 100, d1);
    chk("a5_done_at", d1 - s, 390);
    chk("a5_busy_after", busy_o[0], 0);
    chk("a5_tx_after", tx_o[0], 1);
    count_done(0, 50, cnt);
    chk("a5_one_tick", cnt, 0);

    // 0x00 then 0xFF back to back.
    tick(5);
    wr(0, 8'h00);
    wr(0, 8'hFF);
    wait_done(0, 500, d1);
    wait_done(0, 500, d2);
    chk("b2b_spacing", d2 - d1, 390);
    count_done(0, 60, cnt);
    chk("b2b_no_extra", cnt, 0);

    // Six-cycle burst: bytes 1..5 accepted, 6 dropped.
    tick(5);
    for (int k = 1; k <= 6; k++) begin
      tx_start[0] = 1'b1;
      din[0]      = 8'(k);
      @(negedge clk);
      if (k == 4) chk("burst_ready4", tx_ready_o[0], 1);
      if (k == 5) chk("burst_ready5", tx_ready_o[0], 0);
    end
    tx_start[0] = 1'b0;
    chk("burst_model_q", mq[0].size(), 4);
    chk("burst_model_head", mq[0][0], 2);
    chk("burst_model_tail", mq[0][3], 5);
    count_done(0, 5 * 390 + 60, cnt);
    chk("burst_frames", cnt, 5);
    chk("burst_busy_end", busy_o[0], 0);

    // Reset during data bit 3 with two bytes buffered.
    tick(5);
    wr(0, 8'h3C);
    wr(0, 8'hC3);
    wr(0, 8'h5A);
    tick(4 * CPB0 + 9);
    chk("rst_mid_bit3", tx_o[0], 1);
    chk("rst_mid_q", mq[0].size(), 2);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("rst_mid_tx", tx_o[0], 1);
    chk("rst_mid_busy", busy_o[0], 0);
    chk("rst_mid_ready", tx_ready_o[0], 1);
    chk("rst_mid_done", done_o[0], 0);
    count_done(0, 500, cnt);
    chk("rst_mid_no_tick", cnt, 0);

    // 4 clocks per bit, byte 0x80: whole 40-cycle waveform.
    wr(1, 8'h80);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      w[t] = tx_o[1];
    end
    chk("c4_wave", w, 40'hFF00000000);
    @(negedge clk);
    chk("c4_done_at40", done_o[1], 1);

    // Random traffic with din churning every cycle and rare resets.
    for (int k = 0; k < 6000; k++) begin
      tx_start[0] = ($urandom_range(0, 99) < 1);
      tx_start[1] = ($urandom_range(0, 99) < 15);
      for (int i = 0; i < 2; i++) begin
        din[i]   = 8'($urandom);
        rst_n[i] = ($urandom_range(0, 2999) != 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      tx_start[i] = 1'b0; rst_n[i] = 1'b1;
    end
    tick(2500);
    chk("drain_busy0", busy_o[0], 0);
    chk("drain_busy1", busy_o[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
